control_fsm: RTL and testbench

CONTROL_FSM -- requirements
Module: control_fsm

---
 rtl/control_fsm.sv | 233 +++++++++++++++++++++++
 tb/tb_control_fsm.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/control_fsm.sv
// Multi-cycle datapath controller: sequences fetch, decode, ALU, load/store,
// jump and branch phases and drives the datapath select lines and load strobes.
module control_fsm #(
  parameter int WIDTH = 16,
  parameter int PSRL  = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] instr,
  input  logic [PSRL-1:0]  psr,
  input  logic             mem_ready,
  output logic             pc_s,
  output logic             mem_s,
  output logic [1:0]       wd_s,
  output logic [1:0]       alua_s,
  output logic [1:0]       alub_s,
  output logic             inst_en,
  output logic             pc_en,
  output logic             alu_out_en,
  output logic             mem_reg_en,
  output logic             psr_en,
  output logic             reg_wr,
  output logic             mem_wr,
  output logic             se_sign,
  output logic             add_force,
  output logic [3:0]       state
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    RTYPE  = 4'd2,
    ITYPE  = 4'd3,
    ALUWB  = 4'd4,
    MOVI   = 4'd5,
    MEMRD  = 4'd6,
    LDWB   = 4'd7,
    MEMWR  = 4'd8,
    JUMP   = 4'd9,
    BRANCH = 4'd10
  } state_t;

  localparam logic [3:0] OP_RTYPE  = 4'b0000;
  localparam logic [3:0] OP_ADDI   = 4'b0001;
  localparam logic [3:0] OP_SUBI   = 4'b0010;
  localparam logic [3:0] OP_ANDI   = 4'b0011;
  localparam logic [3:0] OP_MEM    = 4'b0100;
  localparam logic [3:0] OP_ADDUI  = 4'b0101;
  localparam logic [3:0] OP_SUBCI  = 4'b1001;
  localparam logic [3:0] OP_CMPI   = 4'b1011;
  localparam logic [3:0] OP_BRANCH = 4'b1100;
  localparam logic [3:0] OP_MOVI   = 4'b1101;

  localparam logic [3:0] EXT_NOP  = 4'b0000;
  localparam logic [3:0] EXT_CMP  = 4'b1011;
  localparam logic [3:0] EXT_LOAD = 4'b0000;
  localparam logic [3:0] EXT_STOR = 4'b0100;
  localparam logic [3:0] EXT_JCND = 4'b1100;

  state_t state_q, state_d;

  logic [3:0] op, rd, ext;
  logic       flag_n, flag_z, flag_f, flag_l, flag_c;
  logic       itype_op, itype_signed, cond_taken;
  logic       unused_bits;

  assign op  = instr[15:12];
  assign rd  = instr[11:8];
  assign ext = instr[7:4];

  assign {flag_n, flag_z, flag_f, flag_l, flag_c} = psr[4:0];

  // Low immediate bits and any extra instr/psr width are the datapath's concern.
  assign unused_bits = ^{instr, psr};

  assign itype_op = (op == OP_ADDI)  || (op == OP_SUBI)  || (op == OP_ANDI) ||
                    (op == OP_ADDUI) || (op == OP_SUBCI) || (op == OP_CMPI);
  assign itype_signed = (op == OP_ADDUI) || (op == OP_SUBCI) || (op == OP_CMPI);

  always_comb begin
    unique case (rd)
      4'b0000: cond_taken = flag_z;
      4'b0001: cond_taken = !flag_z;
      4'b0010: cond_taken = flag_c;
      4'b0011: cond_taken = !flag_c;
      4'b0110: cond_taken = flag_n;
      4'b0111: cond_taken = !flag_n;
      4'b1000: cond_taken = flag_f;
      4'b1001: cond_taken = !flag_f;
      4'b1010: cond_taken = flag_l;
      4'b1011: cond_taken = !flag_l;
      4'b1110: cond_taken = 1'b1;
      default: cond_taken = 1'b0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its inputs regardless of process ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  // NOTE: every output and state_d gets a default before the case statement;
  // any path that skipped an assignment would otherwise infer a latch.
  always_comb begin
    state_d    = FETCH;
    pc_s       = 1'b0;
    mem_s      = 1'b0;
    wd_s       = 2'd0;
    alua_s     = 2'd0;
    alub_s     = 2'd0;
    inst_en    = 1'b0;
    pc_en      = 1'b0;
    alu_out_en = 1'b0;
    mem_reg_en = 1'b0;
    psr_en     = 1'b0;
    reg_wr     = 1'b0;
    mem_wr     = 1'b0;
    se_sign    = 1'b0;
    add_force  = 1'b0;

    // Strobes are gated by reset too, so a fetch cannot fire while held in reset.
    if (reset) begin
      mem_s = 1'b1;
    end else begin
      unique case (state_q)
        FETCH: begin
          mem_s = 1'b1;
          if (mem_ready) begin
            inst_en   = 1'b1;
            pc_en     = 1'b1;
            pc_s      = 1'b1;
            alua_s    = 2'd1;
            alub_s    = 2'd2;
            add_force = 1'b1;
            state_d   = DECODE;
          end else begin
            state_d = FETCH;
          end
        end

        DECODE: begin
          if (op == OP_RTYPE) begin
            state_d = (ext == EXT_NOP) ? FETCH : RTYPE;
          end else if (itype_op) begin
            state_d = ITYPE;
          end else if (op == OP_MOVI) begin
            state_d = MOVI;
          end else if (op == OP_MEM) begin
            unique case (ext)
              EXT_LOAD: state_d = MEMRD;
              EXT_STOR: state_d = MEMWR;
              EXT_JCND: state_d = JUMP;
              default:  state_d = FETCH;
            endcase
          end else if (op == OP_BRANCH) begin
            state_d = BRANCH;
          end else begin
            state_d = FETCH;
          end
        end

        RTYPE: begin
          alu_out_en = 1'b1;
          psr_en     = 1'b1;
          state_d    = (ext == EXT_CMP) ? FETCH : ALUWB;
        end

        ITYPE: begin
          alua_s     = 2'd2;
          se_sign    = itype_signed;
          alu_out_en = 1'b1;
          psr_en     = 1'b1;
          state_d    = (op == OP_CMPI) ? FETCH : ALUWB;
        end

        ALUWB: begin
          wd_s   = 2'd3;
          reg_wr = 1'b1;
        end

        MOVI: begin
          wd_s   = 2'd0;
          reg_wr = 1'b1;
        end

        MEMRD: begin
          if (mem_ready) begin
            mem_reg_en = 1'b1;
            state_d    = LDWB;
          end else begin
            state_d = MEMRD;
          end
        end

        LDWB: begin
          wd_s   = 2'd2;
          reg_wr = 1'b1;
        end

        // mem_wr stays high for the whole stall so the memory sees a stable request.
        MEMWR: begin
          mem_wr  = 1'b1;
          state_d = mem_ready ? FETCH : MEMWR;
        end

        JUMP: begin
          if (cond_taken) begin
            pc_s  = 1'b0;
            pc_en = 1'b1;
          end
        end

        BRANCH: begin
          if (cond_taken) begin
            alua_s    = 2'd1;
            alub_s    = 2'd1;
            se_sign   = 1'b1;
            add_force = 1'b1;
            pc_s      = 1'b1;
            pc_en     = 1'b1;
          end
        end

        default: state_d = FETCH;
      endcase
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_control_fsm.sv
// Directed bench for control_fsm: stimulus pushes hand-written per-cycle output
// expectations into a queue; a negedge monitor pops and compares them.
module tb_control_fsm;

  typedef struct packed {
    logic [3:0] st;
    logic       pc_s;
    logic       mem_s;
    logic [1:0] wd_s;
    logic [1:0] alua_s;
    logic [1:0] alub_s;
    logic       inst_en;
    logic       pc_en;
    logic       alu_out_en;
    logic       mem_reg_en;
    logic       psr_en;
    logic       reg_wr;
    logic       mem_wr;
    logic       se_sign;
    logic       add_force;
  } exp_t;

  typedef struct {
    exp_t  v;
    string name;
  } entry_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] instr;
  logic [4:0]  psr;
  logic        mem_ready;

  logic       pc_s, mem_s, inst_en, pc_en, alu_out_en, mem_reg_en, psr_en;
  logic       reg_wr, mem_wr, se_sign, add_force;
  logic [1:0] wd_s, alua_s, alub_s;
  logic [3:0] state;

  entry_t sb_q[$];
  int     n_checks = 0;
  int     n_fail   = 0;

  always #5 clk = ~clk;

  control_fsm #(.WIDTH(16), .PSRL(5)) dut (
    .clk        (clk),
    .reset      (reset),
    .instr      (instr),
    .psr        (psr),
    .mem_ready  (mem_ready),
    .pc_s       (pc_s),
    .mem_s      (mem_s),
    .wd_s       (wd_s),
    .alua_s     (alua_s),
    .alub_s     (alub_s),
    .inst_en    (inst_en),
    .pc_en      (pc_en),
    .alu_out_en (alu_out_en),
    .mem_reg_en (mem_reg_en),
    .psr_en     (psr_en),
    .reg_wr     (reg_wr),
    .mem_wr     (mem_wr),
    .se_sign    (se_sign),
    .add_force  (add_force),
    .state      (state)
  );

  // Monitor: one popped expectation per cycle, sampled mid-cycle.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      entry_t e;
      exp_t   act;
      e   = sb_q.pop_front();
      act = '{state, pc_s, mem_s, wd_s, alua_s, alub_s, inst_en, pc_en,
              alu_out_en, mem_reg_en, psr_en, reg_wr, mem_wr, se_sign, add_force};
      n_checks++;
      if (act !== e.v) begin
        n_fail++;
        $display("FAIL %s: got st=%0d pc_s=%b mem_s=%b wd=%0d a=%0d b=%0d ie=%b pe=%b ae=%b me=%b fe=%b rw=%b mw=%b se=%b af=%b ; want st=%0d pc_s=%b mem_s=%b wd=%0d a=%0d b=%0d ie=%b pe=%b ae=%b me=%b fe=%b rw=%b mw=%b se=%b af=%b",
                 e.name, act.st, act.pc_s, act.mem_s, act.wd_s, act.alua_s, act.alub_s,
                 act.inst_en, act.pc_en, act.alu_out_en, act.mem_reg_en, act.psr_en,
                 act.reg_wr, act.mem_wr, act.se_sign, act.add_force,
                 e.v.st, e.v.pc_s, e.v.mem_s, e.v.wd_s, e.v.alua_s, e.v.alub_s,
                 e.v.inst_en, e.v.pc_en, e.v.alu_out_en, e.v.mem_reg_en, e.v.psr_en,
                 e.v.reg_wr, e.v.mem_wr, e.v.se_sign, e.v.add_force);
      end
    end
  end

  function automatic exp_t z(input logic [3:0] st);
    exp_t x;
    x    = '0;
    x.st = st;
    return x;
  endfunction

  function automatic exp_t fetch_idle();
    exp_t x;
    x       = z(4'd0);
    x.mem_s = 1'b1;
    return x;
  endfunction

  function automatic exp_t fetch_go();
    exp_t x;
    x           = fetch_idle();
    x.inst_en   = 1'b1;
    x.pc_en     = 1'b1;
    x.pc_s      = 1'b1;
    x.alua_s    = 2'd1;
    x.alub_s    = 2'd2;
    x.add_force = 1'b1;
    return x;
  endfunction

  // Called just after a rising edge: apply mem_ready, queue this cycle's
  // expected outputs, then advance to just after the next rising edge.
  task automatic step(input logic mr, input exp_t ex, input string name);
    entry_t e;
    mem_ready = mr;
    e.v       = ex;
    e.name    = name;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Completes a fetch of iw followed by the decode cycle.
  task automatic fetch_decode(input logic [15:0] iw, input string name);
    instr = iw;
    step(1'b1, fetch_go(), {name, "_fetch"});
    step(1'b0, z(4'd1), {name, "_decode"});
  endtask

  exp_t x;

  initial begin
    reset     = 1'b1;
    instr     = 16'h0000;
    psr       = 5'b00000;
    mem_ready = 1'b1;
    @(posedge clk);
    #1;

    // Reset held with mem_ready high: no strobes, mem_s=1.
    step(1'b1, fetch_idle(), "reset_hold");
    reset = 1'b0;

    // Fetch stall.
    step(1'b0, fetch_idle(), "fetch_stall");

    // R-type ADD 0x0251.
    fetch_decode(16'h0251, "add");
    x = z(4'd2); x.alu_out_en = 1'b1; x.psr_en = 1'b1;
    step(1'b1, x, "add_rtype");
    x = z(4'd4); x.wd_s = 2'd3; x.reg_wr = 1'b1;
    step(1'b1, x, "add_aluwb");

    // CMP 0x02B1: RTYPE then straight back to FETCH.
    fetch_decode(16'h02B1, "cmp");
    x = z(4'd2); x.alu_out_en = 1'b1; x.psr_en = 1'b1;
    step(1'b1, x, "cmp_rtype");

    // NOP.
    fetch_decode(16'h0000, "nop");

    // LOAD 0x4103 with two stall cycles.
    fetch_decode(16'h4103, "load");
    step(1'b0, z(4'd6), "load_stall1");
    step(1'b0, z(4'd6), "load_stall2");
    x = z(4'd6); x.mem_reg_en = 1'b1;
    step(1'b1, x, "load_done");
    x = z(4'd7); x.wd_s = 2'd2; x.reg_wr = 1'b1;
    step(1'b1, x, "load_ldwb");

    // STOR 0x4342 with three stall cycles.
    fetch_decode(16'h4342, "stor");
    x = z(4'd8); x.mem_wr = 1'b1;
    step(1'b0, x, "stor_stall1");
    step(1'b0, x, "stor_stall2");
    step(1'b0, x, "stor_stall3");
    step(1'b1, x, "stor_done");

    // BRANCH EQ 0xC0FE, Z set then clear.
    psr = 5'b01000;
    fetch_decode(16'hC0FE, "beq_t");
    x = z(4'd10); x.alua_s = 2'd1; x.alub_s = 2'd1; x.se_sign = 1'b1;
    x.add_force = 1'b1; x.pc_s = 1'b1; x.pc_en = 1'b1;
    step(1'b1, x, "beq_taken");
    psr = 5'b10111;
    fetch_decode(16'hC0FE, "beq_n");
    step(1'b1, z(4'd10), "beq_not_taken");

    // Unconditional jump 0x4EC0, then JCS 0x42C0 with C clear.
    fetch_decode(16'h4EC0, "juc");
    x = z(4'd9); x.pc_en = 1'b1;
    step(1'b1, x, "jump_always");
    psr = 5'b11110;
    fetch_decode(16'h42C0, "jcs");
    step(1'b1, z(4'd9), "jump_cs_not_taken");

    // ADDI 0x1305 (zero-extend), MOVI 0xD17F.
    fetch_decode(16'h1305, "addi");
    x = z(4'd3); x.alua_s = 2'd2; x.alu_out_en = 1'b1; x.psr_en = 1'b1;
    step(1'b1, x, "addi_itype");
    x = z(4'd4); x.wd_s = 2'd3; x.reg_wr = 1'b1;
    step(1'b1, x, "addi_aluwb");
    fetch_decode(16'hD17F, "movi");
    x = z(4'd5); x.reg_wr = 1'b1;
    step(1'b1, x, "movi_wb");

    // Undefined op 0xF000 and op 4 with unused ext 0x4120: decode back to FETCH.
    fetch_decode(16'hF000, "undef");
    fetch_decode(16'h4120, "mem_bad_ext");

    // CMPI 0xB305: sign-extended, psr_en without writeback.
    fetch_decode(16'hB305, "cmpi");
    x = z(4'd3); x.alua_s = 2'd2; x.se_sign = 1'b1; x.alu_out_en = 1'b1; x.psr_en = 1'b1;
    step(1'b1, x, "cmpi_itype");

    // Reset pulse in the middle of a STOR stall.
    fetch_decode(16'h4342, "stor_rst");
    x = z(4'd8); x.mem_wr = 1'b1;
    step(1'b0, x, "stor_rst_stall");
    reset = 1'b1;
    step(1'b1, fetch_idle(), "stor_rst_abort");
    reset = 1'b0;
    fetch_decode(16'h0251, "post_rst");
    x = z(4'd2); x.alu_out_en = 1'b1; x.psr_en = 1'b1;
    step(1'b1, x, "post_rst_rtype");
    x = z(4'd4); x.wd_s = 2'd3; x.reg_wr = 1'b1;
    step(1'b1, x, "post_rst_aluwb");
    step(1'b0, fetch_idle(), "post_rst_fetch");

    // Bounded drain of the scoreboard.
    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
    #1;
    if (sb_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", sb_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
